// File: rtl/imm_narrow_packer_pkg.sv
// Shared encodings for the immediate narrowing packer: chunk kinds, FSM
// states and default widths.
package imm_narrow_packer_pkg;

  localparam int WIDE_W_DEF   = 32;
  localparam int NARROW_W_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  // Kind tag carried with every emitted chunk; 2'b11 is reserved and never driven.
  typedef enum logic [1:0] {
    CHUNK_SHORT = 2'b00,
    CHUNK_HI    = 2'b01,
    CHUNK_LO    = 2'b10
  } chunk_kind_e;

  // Packer state: what, if anything, is currently being presented downstream.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    S_SHORT = 2'b01,
    S_HI    = 2'b10,
    S_LO    = 2'b11
  } pack_state_e;

endpackage : imm_narrow_packer_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/imm_narrow_packer.sv
// Packs 32-bit constants into 16-bit immediate chunks: words that survive
// 16->32 sign extension go out as one SHORT chunk, all others as a HI/LO pair
// (lui/ori style). Valid/ready on both sides, outputs decoded from registers.
module imm_narrow_packer
  import imm_narrow_packer_pkg::*;
#(
  parameter int WIDE_W   = WIDE_W_DEF,
  parameter int NARROW_W = NARROW_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NARROW_W-1:0] out_data,
  output logic [1:0]          out_kind,
  output logic                out_last,
  output logic [CNT_W-1:0]    short_cnt,
  output logic [CNT_W-1:0]    split_cnt
);

  pack_state_e       state_q, state_d;
  logic [WIDE_W-1:0] hold_q;
  logic              in_fire;
  logic              out_fire;
  logic              fits;
  logic              last_leaving;

  // Bits [WIDE_W-1:NARROW_W-1] all equal means sign extension of the low
  // half reproduces the word exactly.
  assign fits = (&in_data[WIDE_W-1:NARROW_W-1]) | ~(|in_data[WIDE_W-1:NARROW_W-1]);

  assign out_fire     = out_valid & out_ready;
  // The final chunk of a word is leaving, so a new word may be taken in the
  // same cycle; this is what gives back-to-back SHORT throughput.
  assign last_leaving = out_fire & ((state_q == S_SHORT) | (state_q == S_LO));
  assign in_ready     = (state_q == IDLE) | last_leaving;
  assign in_fire      = in_valid & in_ready;

  // Next-state: load a new word when one is accepted, advance HI->LO on
  // handshake, otherwise hold.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) state_d = fits ? S_SHORT : S_HI;
      end
      S_HI: begin
        if (out_fire) state_d = S_LO;
      end
      S_SHORT, S_LO: begin
        if (out_fire) begin
          if (in_fire) state_d = fits ? S_SHORT : S_HI;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and held word registers; a reset mid-split drops the pending LO.
  always_ff @(posedge clk) begin
    // NOTE: hold_q is reset too so out_data is deterministic even before the first word.
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) hold_q <= in_data;
    end
  end

  // Output decode purely from registered state and held word.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_kind  = CHUNK_SHORT;
    out_last  = 1'b0;
    unique case (state_q)
      S_SHORT: begin
        out_valid = 1'b1;
        out_data  = hold_q[NARROW_W-1:0];
        out_kind  = CHUNK_SHORT;
        out_last  = 1'b1;
      end
      S_HI: begin
        out_valid = 1'b1;
        out_data  = hold_q[WIDE_W-1:NARROW_W];
        out_kind  = CHUNK_HI;
        out_last  = 1'b0;
      end
      S_LO: begin
        out_valid = 1'b1;
        out_data  = hold_q[NARROW_W-1:0];
        out_kind  = CHUNK_LO;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_short_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_fire & fits),
    .count (short_cnt)
  );

  sat_counter #(.W(CNT_W)) u_split_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_fire & ~fits),
    .count (split_cnt)
  );

endmodule : imm_narrow_packer

// File: tb/tb_imm_narrow_packer.sv
// Self-checking bench for imm_narrow_packer: directed literal cases plus a
// randomized run against a queue-based chunk model with saturating counters.
module tb_imm_narrow_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_kind;
  logic        out_last;
  logic [15:0] short_cnt;
  logic [15:0] split_cnt;

  imm_narrow_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_last  (out_last),
    .short_cnt (short_cnt),
    .split_cnt (split_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] data;
    logic [1:0]  kind;
    logic        last;
    logic [31:0] word;
  } chunk_t;

  chunk_t      q[$];
  int          m_short = 0;
  int          m_split = 0;
  int          n_acc   = 0;
  bit          mon_en  = 0;
  logic [15:0] hi_act;

  function automatic bit word_fits(input logic [31:0] w);
    return ($signed(w) >= -32768) && ($signed(w) <= 32767);
  endfunction

  // Compare every cycle at the falling edge, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      bit     exp_valid, exp_ready;
      chunk_t c;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || ((q.size() == 1) && out_ready);
      check("mon_out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("mon_out_data", 32'(out_data), 32'(q[0].data));
        check("mon_out_kind", 32'(out_kind), 32'(q[0].kind));
        check("mon_out_last", 32'(out_last), 32'(q[0].last));
      end else begin
        check("mon_idle_data", 32'(out_data), 32'h0);
        check("mon_idle_kind", 32'(out_kind), 32'h0);
        check("mon_idle_last", 32'(out_last), 32'h0);
      end
      check("mon_short_cnt", 32'(short_cnt), 32'(m_short));
      check("mon_split_cnt", 32'(split_cnt), 32'(m_split));
      if (rst) begin
        q.delete();
        m_short = 0;
        m_split = 0;
      end else begin
        check("mon_in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_valid && out_ready) begin
          c = q.pop_front();
          if (c.kind == 2'b01) hi_act = out_data;
          else if (c.kind == 2'b10) check("recon_split", {hi_act, out_data}, c.word);
          else check("recon_short", {{16{out_data[15]}}, out_data}, c.word);
        end
        if (in_valid && exp_ready) begin
          n_acc++;
          if (word_fits(in_data)) begin
            q.push_back('{data: in_data[15:0], kind: 2'b00, last: 1'b1, word: in_data});
            if (m_short < 16'hFFFF) m_short++;
          end else begin
            q.push_back('{data: in_data[31:16], kind: 2'b01, last: 1'b0, word: in_data});
            q.push_back('{data: in_data[15:0],  kind: 2'b10, last: 1'b1, word: in_data});
            if (m_split < 16'hFFFF) m_split++;
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_out(input string tag, input logic v, input logic [15:0] d,
                            input logic [1:0] k, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_kind"},  32'(out_kind),  32'(k));
    check({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic split_word(input string tag, input logic [31:0] w,
                            input logic [15:0] hi, input logic [15:0] lo);
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    expect_out({tag, "_hi"}, 1'b1, hi, 2'b01, 1'b0);
    check({tag, "_hi_in_ready"}, 32'(in_ready), 32'h0);
    tick();
    expect_out({tag, "_lo"}, 1'b1, lo, 2'b10, 1'b1);
    tick();
    check({tag, "_idle"}, 32'(out_valid), 32'h0);
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] bnd[6];
    logic [15:0] h;
    bnd = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000,
            32'hFFFF_7FFF, 32'h0000_0000, 32'hFFFF_FFFF};
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return {{16{h[15]}}, h};
      1:       return bnd[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold_pending;
    int start_acc, cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    mon_en = 1;
    tick(); tick();
    expect_out("reset", 1'b0, 16'h0, 2'b00, 1'b0);
    check("reset_short_cnt", 32'(short_cnt), 32'h0);
    check("reset_split_cnt", 32'(split_cnt), 32'h0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back SHORT boundary words.
    in_valid = 1'b1; in_data = 32'h0000_7FFF; out_ready = 1'b1;
    tick();
    in_data = 32'hFFFF_8000;
    #1;
    expect_out("short_7fff", 1'b1, 16'h7FFF, 2'b00, 1'b1);
    check("short_7fff_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    #1;
    expect_out("short_8000", 1'b1, 16'h8000, 2'b00, 1'b1);
    check("short_8000_in_ready", 32'(in_ready), 32'h1);
    check("short_pair_short_cnt", 32'(short_cnt), 32'h2);
    check("short_pair_split_cnt", 32'(split_cnt), 32'h0);
    tick();

    split_word("split_12345678", 32'h1234_5678, 16'h1234, 16'h5678);
    check("split_cnt_one", 32'(split_cnt), 32'h1);
    split_word("split_00008000", 32'h0000_8000, 16'h0000, 16'h8000);
    split_word("split_ffff7fff", 32'hFFFF_7FFF, 16'hFFFF, 16'h7FFF);

    // Backpressure on HI, with a SHORT word waiting behind it.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_out("bp_hi_stall", 1'b1, 16'hDEAD, 2'b01, 1'b0);
      check("bp_hi_stall_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    expect_out("bp_hi_release", 1'b1, 16'hDEAD, 2'b01, 1'b0);
    tick();
    #1;
    expect_out("bp_lo", 1'b1, 16'hBEEF, 2'b10, 1'b1);
    check("bp_lo_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    #1;
    expect_out("bp_short_5", 1'b1, 16'h0005, 2'b00, 1'b1);
    tick();

    // Reset while the LO half is pending.
    in_valid = 1'b1; in_data = 32'hAAAA_5555; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    expect_out("midrst_hi", 1'b1, 16'hAAAA, 2'b01, 1'b0);
    tick();
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_short_cnt", 32'(short_cnt), 32'h0);
    check("midrst_split_cnt", 32'(split_cnt), 32'h0);
    check("midrst_in_ready",  32'(in_ready),  32'h1);
    tick(); tick();
    check("midrst_no_lo", 32'(out_valid), 32'h0);

    // Saturation of short_cnt.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_data = (i % 2 == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("sat_short_cnt", 32'(short_cnt), 32'h0000_FFFF);
    check("sat_split_cnt", 32'(split_cnt), 32'h0);

    // Randomized traffic with backpressure, checked by the monitor.
    hold_pending = 0;
    start_acc = n_acc;
    cyc = 0;
    while ((n_acc - start_acc < 3000) && (cyc < 20000)) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold_pending) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if (in_valid) in_data = gen_word();
      end
      #1;
      hold_pending = in_valid && !in_ready;
      tick();
      cyc++;
    end
    check("rand_words_accepted", 32'(n_acc - start_acc >= 3000), 32'h1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0) && (cyc < 10)) begin
      tick();
      cyc++;
    end
    check("rand_drained", 32'(q.size()), 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_imm_narrow_packer
